// File: rtl/seq_divider_32_16.sv
// Sequential 32/16 unsigned restoring divider, one quotient bit per cycle.
// Valid/ready on both sides; divide-by-zero and overflow resolve at accept.
module seq_divider_32_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] r;
  logic [15:0] q;
  logic [15:0] dvs;

  logic [16:0] t;
  logic        ge;
  logic [15:0] diff;
  logic [15:0] r_nx;
  logic [15:0] q_nx;
  logic        nz;
  logic        hi_ge;

  // r < dvs holds before every step, so the difference fits in 16 bits
  assign t     = {r, q[15]};
  assign ge    = t >= {1'b0, dvs};
  assign diff  = t[15:0] - dvs;
  assign r_nx  = ge ? diff : t[15:0];
  assign q_nx  = {q[14:0], ge};
  assign nz    = divisor != 16'd0;
  assign hi_ge = dividend[31:16] >= divisor;

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      r           <= 16'd0;
      q           <= 16'd0;
      dvs         <= 16'd0;
      quotient    <= 16'd0;
      remainder   <= 16'd0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            unique case (1'b1)
              !nz: begin
                state       <= DONE;
                quotient    <= 16'hFFFF;
                remainder   <= dividend[15:0];
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
              end
              nz && hi_ge: begin
                state       <= DONE;
                quotient    <= 16'hFFFF;
                remainder   <= 16'h0000;
                div_by_zero <= 1'b0;
                overflow    <= 1'b1;
              end
              nz && !hi_ge: begin
                state <= CALC;
                cnt   <= 4'd0;
                r     <= dividend[31:16];
                q     <= dividend[15:0];
                dvs   <= divisor;
              end
            endcase
          end
        end
        CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state       <= DONE;
            quotient    <= q_nx;
            remainder   <= r_nx;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider_32_16.md
# seq_divider_32_16

Sequential 32-by-16 unsigned restoring divider: the inverse datapath of the 16x16 Karatsuba multiplier. Given a 32-bit product-width dividend and a 16-bit divisor, it returns a 16-bit quotient and a 16-bit remainder, so that `divide(x*y, y)` recovers `x`. It sits beside the multiplier in the arithmetic unit. It uses valid/ready handshakes on both sides and computes one quotient bit per cycle.

## Interface
Parameters: none (widths fixed: 32-bit dividend, 16-bit divisor/quotient/remainder).

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operands valid
- in_ready  out  1  block idle, can accept operands
- dividend  in  32  unsigned dividend
- divisor  in  16  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  16  unsigned quotient
- remainder  out  16  unsigned remainder
- div_by_zero  out  1  divisor was 0
- overflow  out  1  quotient does not fit in 16 bits (dividend[31:16] >= divisor, divisor != 0)

## Operation
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE); out_valid = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- **Accept:** in_valid && in_ready at a rising edge captures dividend and divisor. Later input changes are ignored until the next accept.
- **Classification at accept:**
  - divisor == 0 -> DONE with div_by_zero=1, overflow=0, quotient=16'hFFFF, remainder=dividend[15:0].
  - Else if dividend[31:16] >= divisor -> DONE with overflow=1, div_by_zero=0, quotient=16'hFFFF, remainder=16'h0000.
  - Else -> CALC, with iteration counter=0, partial remainder r (17 bits) = {0, dividend[31:16]}, q = dividend[15:0].
- **CALC step (one per edge):**
  - t = {r[15:0], q[15]}.
  - If t >= divisor: r = t - divisor and q = {q[14:0],1}; else r = t and q = {q[14:0],0}.
  - The counter increments each step. After the 16th step, the block enters DONE with quotient=q, remainder=r[15:0], and both flags 0.
  - Invariant: r < divisor before each step, so 17 bits suffice and no bits are lost.
- **DONE:** quotient, remainder and flags are held stable while out_valid=1. out_valid && out_ready at an edge -> IDLE.
- No same-cycle result/accept overlap: a new accept is possible no earlier than the cycle after the result handshake.
- in_valid asserted during CALC or DONE is ignored; it is not queued.

## Timing
- **Reset (rst_n=0, asynchronous):**
  - State=IDLE and counter=0.
  - quotient, remainder, div_by_zero, overflow, out_valid = 0; in_ready = 1 once reset is held.
- **Reset mid-CALC or mid-DONE:** the in-flight operation is discarded and no out_valid pulse is emitted. After rst_n rises, the first accept is possible on the first clock edge.
- **Latency, accept edge E0:**
  - Normal: CALC occupies edges E1..E16, and out_valid is high after E16 (16 cycles).
  - Divide-by-zero and overflow: out_valid is high after E0 (1 cycle).
- **Throughput:** normal ops take at least 18 cycles each (accept + 16 CALC + result handshake in DONE); exception ops take at least 2 cycles.
- **Backpressure:** DONE persists indefinitely while out_ready=0.
- out_ready while not out_valid has no effect.

## Test plan
- **Multiplier round trip:** dividend=200, divisor=20 -> out_valid exactly 16 cycles after accept; quotient=10, remainder=0, flags 0. Also dividend=15609 (121*129), divisor=129 -> q=121, r=0. Also dividend=15610, divisor=129 -> q=121, r=1.
- **Max operands:** dividend=32'hFFFE0001 (65535^2), divisor=16'hFFFF -> q=16'hFFFF, r=0, overflow=0. Also dividend=32'h0000FFFF, divisor=1 -> q=16'hFFFF, r=0.
- **Exceptions:**
  - dividend=1234, divisor=0 -> out_valid 1 cycle after accept; div_by_zero=1, q=16'hFFFF, r=16'h04D2.
  - dividend=32'h00010000, divisor=1 -> overflow=1, q=16'hFFFF, r=0.
  - dividend=32'h00050000, divisor=5 -> overflow=1.
- **Handshake and backpressure:**
  - Hold out_ready=0 for 5 cycles in DONE -> outputs bit-stable and in_ready=0.
  - Toggle in_valid with new operands during CALC -> result still matches the originally accepted operands.
  - Release out_ready -> in_ready=1 on the following cycle.
- **Reset mid-operation:** assert rst_n=0 asynchronously (between edges) after the 8th CALC edge -> all outputs 0 and in_ready=1 immediately. After release, a new op 100/7 -> q=14, r=2 with full 16-cycle latency and no stale out_valid.
- **Random regression:** 1000 random dividend/divisor pairs, compared against a reference model using / and %, with flags checked against the classification rules.
